// File: rtl/alu.sv
// Registered integer ALU for the execute stage.
// Computes AND/OR/ADD/XOR/SUB/SLL/SRL on two WIDTH-bit operands and captures
// the result one clock after in_valid. Unassigned operation codes yield 0.
// Zero is decoded combinationally from the Result register so it always
// tracks the stored value, including during reset and while holding.
module alu #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  logic [WIDTH-1:0]   r_result;
  logic               r_outValid;
  logic [WIDTH-1:0]   w_nextResult;
  logic [SHAMT_W-1:0] w_shamt;

  // Only the low SHAMT_W bits of B select the shift distance.
  assign w_shamt = B[SHAMT_W-1:0];

  // Operation decode; any code not listed produces an all-zero result.
  always_comb begin
    w_nextResult = '0;
    unique case (ALUControl)
      OP_AND:  w_nextResult = A & B;
      OP_OR:   w_nextResult = A | B;
      OP_ADD:  w_nextResult = A + B;
      OP_XOR:  w_nextResult = A ^ B;
      OP_SUB:  w_nextResult = A - B;
      OP_SLL:  w_nextResult = A << w_shamt;
      OP_SRL:  w_nextResult = A >> w_shamt;
      default: w_nextResult = '0;
    endcase
  end

  // Capture the result on valid operands; otherwise hold it and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= in_valid;
      if (in_valid) begin
        r_result <= w_nextResult;
      end
    end
  end

  assign Result    = r_result;
  assign out_valid = r_outValid;
  assign Zero      = (r_result == '0);

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
// Each step drives operands on the falling edge, lets the rising edge capture,
// then samples 1 time unit later and compares against hand-computed values.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic [63:0] Result;
  logic        Zero;

  int checks;
  int errors;

  alu #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .Result     (Result),
    .Zero       (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkValue(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare all three outputs against the expected values.
  task automatic checkOutput(input string tag, input logic [63:0] expResult,
                             input logic expZero, input logic expValid);
    checkValue({tag, ".Result"}, Result, expResult);
    checkValue({tag, ".Zero"}, {63'd0, Zero}, {63'd0, expZero});
    checkValue({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, expValid});
  endtask

  // Drive one cycle of inputs on the falling edge, then step past the capture edge.
  task automatic applyStimulus(input logic v, input logic [63:0] a,
                               input logic [63:0] b, input logic [3:0] op);
    @(negedge clk);
    in_valid   = v;
    A          = a;
    B          = b;
    ALUControl = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    A          = '0;
    B          = '0;
    ALUControl = 4'b0000;

    #12;
    checkOutput("reset_initial", 64'd0, 1'b1, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 64'd100, 64'd50, 4'b0010);
    checkOutput("add_100_50", 64'd150, 1'b0, 1'b1);

    // Reset while a new operation is presented: clears immediately.
    @(negedge clk);
    in_valid   = 1'b1;
    A          = 64'd7;
    B          = 64'd8;
    ALUControl = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 64'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_holds_capture", 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    applyStimulus(1'b1, 64'd100, 64'd50, 4'b0010);
    checkOutput("add_after_reset", 64'd150, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_0000_0000, 4'b0000);
    checkOutput("and", 64'hAAAA_AAAA_0000_0000, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 4'b0001);
    checkOutput("or", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'h1234_5678_1234_5678, 64'h1234_5678_1234_5678, 4'b0100);
    checkOutput("xor_self", 64'd0, 1'b1, 1'b1);

    applyStimulus(1'b1, 64'h0F0F_0000_0000_00FF, 64'h00FF_0000_0000_0F0F, 4'b0100);
    checkOutput("xor_mixed", 64'h0FF0_0000_0000_0FF0, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'd100, 64'd50, 4'b0110);
    checkOutput("sub_100_50", 64'd50, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'd0, 64'd1, 4'b0110);
    checkOutput("sub_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    checkOutput("add_wrap", 64'd0, 1'b1, 1'b1);

    applyStimulus(1'b1, 64'd1, 64'd4, 4'b1000);
    checkOutput("sll_4", 64'h10, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'h80, 64'd4, 4'b1001);
    checkOutput("srl_4", 64'h8, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'd1, 64'h40, 4'b1000);
    checkOutput("sll_upper_ignored", 64'd1, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'd1, 64'd63, 4'b1000);
    checkOutput("sll_63", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'h8000_0000_0000_0000, 64'd63, 4'b1001);
    checkOutput("srl_63", 64'd1, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'hF000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FF00, 4'b1001);
    checkOutput("srl_0", 64'hF000_0000_0000_000F, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'd33, 64'd33, 4'b1111);
    checkOutput("invalid_1111", 64'd0, 1'b1, 1'b1);

    applyStimulus(1'b1, 64'd5, 64'd9, 4'b0010);
    checkOutput("add_5_9", 64'd14, 1'b0, 1'b1);

    applyStimulus(1'b1, 64'd33, 64'd33, 4'b0011);
    checkOutput("invalid_0011", 64'd0, 1'b1, 1'b1);

    // Back-to-back operations land on consecutive cycles.
    applyStimulus(1'b1, 64'd1000, 64'd234, 4'b0010);
    checkOutput("b2b_add", 64'd1234, 1'b0, 1'b1);
    applyStimulus(1'b1, 64'd1000, 64'd1, 4'b0110);
    checkOutput("b2b_sub", 64'd999, 1'b0, 1'b1);

    // Idle cycles hold the last result with out_valid low; inputs changed to catch leaks.
    applyStimulus(1'b0, 64'd3, 64'd4, 4'b0010);
    checkOutput("hold_1", 64'd999, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'd0, 64'd0, 4'b0000);
    checkOutput("hold_2", 64'd999, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'hFFFF, 64'd1, 4'b1000);
    checkOutput("hold_3", 64'd999, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
